width_conv_fifo: RTL and testbench
==================================

WIDTH_CONV_FIFO -- requirements
Module: width_conv_fifo

Interface
REQ-001 Parameter WR_W, default 16, write word width in bits.
REQ-002 Parameter RD_W, default 24, read word width in bits.
REQ-003 Parameter DEPTH_BITS, default 512, storage capacity in bits; power of two, >= 2*(WR_W+RD_W).
REQ-004 Parameters HW_LEVEL, default 384; LW_LEVEL, default 128; HYST, default 32; all in bits; LW_LEVEL+HYST < HW_LEVEL-HYST.
REQ-005 Port clk143  input  1  sole clock; all state changes on its rising edge.
REQ-006 Port reset_n  input  1  reset; asynchronous, active-low.
REQ-007 Port we  input  1  write request for din.
REQ-008 Port din  input  WR_W  write word; din[0] is the oldest bit.
REQ-009 Port pop_front  input  1  read request for RD_W bits.
REQ-010 Port clr_err  input  1  clears the sticky error flags.
REQ-011 Port dout  output  RD_W  registered read word; dout[0] is the oldest bit.
REQ-012 Port dout_valid  output  1  high for one cycle when dout holds a newly popped word.
REQ-013 Port level  output  $clog2(DEPTH_BITS)+1  stored bit count.
REQ-014 Port full, empty  output  1 each  full = (DEPTH_BITS-level < WR_W); empty = (level < RD_W); combinational from level.
REQ-015 Port buf_hw, buf_lw  output  1 each  registered high/low watermark flags.
REQ-016 Port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Storage is a circular bit array with wr_ptr/rd_ptr modulo DEPTH_BITS; level register tracks occupancy.
REQ-018 Write accepted when we && !full: WR_W bits stored from wr_ptr upward; wr_ptr += WR_W.
REQ-019 Pop accepted when pop_front && !empty: dout <= RD_W bits from rd_ptr upward; rd_ptr += RD_W; dout_valid <= 1 on the same edge (latency 1 cycle).
REQ-020 No accepted pop: dout_valid <= 0, dout holds its last value.
REQ-021 Slices crossing the array end wrap modulo DEPTH_BITS with no bit loss or reordering.
REQ-022 Simultaneous accepted write and pop: full and empty both evaluated on pre-edge level; level += WR_W-RD_W; a pop does not free space for a same-cycle write.
REQ-023 Rejected write (we && full) sets overflow; storage, wr_ptr, level unchanged.
REQ-024 Rejected pop (pop_front && empty) sets underflow; rd_ptr, level, dout unchanged; dout_valid <= 0.
REQ-025 clr_err clears overflow and underflow; a new error in the same cycle wins (flag stays set).
REQ-026 Watermarks evaluated on next-state level, updated on the same edge as level.
REQ-027 buf_hw sets when level > HW_LEVEL; clears when level <= HW_LEVEL-HYST; otherwise holds.
REQ-028 buf_lw sets when level < LW_LEVEL; clears when level >= LW_LEVEL+HYST; otherwise holds.

Reset
REQ-029 reset_n low: wr_ptr, rd_ptr, level, dout = 0; dout_valid, full, buf_hw, overflow, underflow = 0; empty, buf_lw = 1; storage contents not reset.
REQ-030 Reset asserted mid-operation discards all stored data immediately; first write after release lands at bit 0.

Verification
REQ-031 Release reset -> level=0, empty=1, full=0, buf_lw=1, buf_hw=0, dout_valid=0.
REQ-032 Write 0xBBAA, 0xDDCC, 0xFFEE, then two pops -> dout=0xCCBBAA then 0xFFEEDD, each with dout_valid for one cycle; level 48->24->0.
REQ-033 32 writes -> level=512, full=1, buf_hw set after 25th write (level 400); 33rd write -> overflow=1, level stays 512; clr_err -> overflow=0.
REQ-034 level=16, pop -> underflow=1, dout_valid=0, level=16, dout unchanged.
REQ-035 At level=24, we+pop_front same cycle -> level=16, dout correct, no error; streaming write/pop past 512 bits with rd_ptr=504 at one pop -> wrapped word intact.
REQ-036 Drain from 400 bits -> buf_hw stays 1 until level <= 352; buf_lw sets at level < 128, clears only at level >= 160 on refill.

Source files
------------

// File: rtl/width_conv_fifo.sv
// width_conv_fifo: bit-granular circular FIFO that accepts WR_W-bit words and delivers RD_W-bit words
//   clk143/reset_n           : clock, asynchronous active-low reset
//   we/din                   : write request and word (din[0] oldest bit)
//   pop_front/dout/dout_valid: read request, registered read word, one-cycle valid
//   level/full/empty         : stored bit count and derived space flags
//   buf_hw/buf_lw            : registered watermark flags with hysteresis
//   overflow/underflow       : sticky error flags, cleared by clr_err
module width_conv_fifo #(
  parameter int WR_W = 16,
  parameter int RD_W = 24,
  parameter int DEPTH_BITS = 512,
  parameter int HW_LEVEL = 384,
  parameter int LW_LEVEL = 128,
  parameter int HYST = 32
) (
  input  logic                          clk143,
  input  logic                          reset_n,
  input  logic                          we,
  input  logic [WR_W-1:0]               din,
  input  logic                          pop_front,
  input  logic                          clr_err,
  output logic [RD_W-1:0]               dout,
  output logic                          dout_valid,
  output logic [$clog2(DEPTH_BITS):0]   level,
  output logic                          full,
  output logic                          empty,
  output logic                          buf_hw,
  output logic                          buf_lw,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int PW = $clog2(DEPTH_BITS);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] WR_L = LW'(WR_W);
  localparam logic [LW-1:0] RD_L = LW'(RD_W);
  localparam logic [LW-1:0] FULL_TH = LW'(DEPTH_BITS - WR_W);
  localparam logic [LW-1:0] HW_SET = LW'(HW_LEVEL);
  localparam logic [LW-1:0] HW_CLR = LW'(HW_LEVEL - HYST);
  localparam logic [LW-1:0] LW_SET = LW'(LW_LEVEL);
  localparam logic [LW-1:0] LW_CLR = LW'(LW_LEVEL + HYST);
  logic [DEPTH_BITS-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [RD_W-1:0] dout_q, dout_d, rd_word;
  logic dout_valid_q, dout_valid_d, hw_q, hw_d, lw_q, lw_d, ovf_q, ovf_d, unf_q, unf_d;
  logic wr_ok, rd_ok;
  // full means the free space cannot take a whole write word
  assign full = level_q > FULL_TH;
  assign empty = level_q < RD_L;
  assign level = level_q;
  assign dout = dout_q;
  assign dout_valid = dout_valid_q;
  assign buf_hw = hw_q;
  assign buf_lw = lw_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  // pointer arithmetic is PW bits wide, so slices wrap around the array end for free
  always_comb begin
    wr_ok = we && !full;
    rd_ok = pop_front && !empty;
    mem_d = mem_q;
    for (int i = 0; i < WR_W; i++)
      if (wr_ok) mem_d[wr_ptr_q + PW'(i)] = din[i];
    rd_word = '0;
    for (int i = 0; i < RD_W; i++)
      rd_word[i] = mem_q[rd_ptr_q + PW'(i)];
    wr_ptr_d = wr_ok ? wr_ptr_q + PW'(WR_W) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PW'(RD_W) : rd_ptr_q;
    dout_d = rd_ok ? rd_word : dout_q;
    dout_valid_d = rd_ok;
    level_d = level_q + (wr_ok ? WR_L : '0) - (rd_ok ? RD_L : '0);
    hw_d = level_d > HW_SET ? 1'b1 : level_d <= HW_CLR ? 1'b0 : hw_q;
    lw_d = level_d < LW_SET ? 1'b1 : level_d >= LW_CLR ? 1'b0 : lw_q;
    // a fresh error outranks a same-cycle clear
    ovf_d = (we && full) || (ovf_q && !clr_err);
    unf_d = (pop_front && empty) || (unf_q && !clr_err);
  end
  always_ff @(posedge clk143) mem_q <= mem_d;
  always_ff @(posedge clk143 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      hw_q <= 1'b0;
      lw_q <= 1'b1;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      dout_q <= dout_d;
      dout_valid_q <= dout_valid_d;
      hw_q <= hw_d;
      lw_q <= lw_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
endmodule

// File: tb/tb_width_conv_fifo.sv
// tb_width_conv_fifo: scoreboard bench for width_conv_fifo with a bit-queue reference model
module tb_width_conv_fifo;
  logic clk143 = 1'b0;
  logic reset_n, we, pop_front, clr_err;
  logic [15:0] din;
  logic [23:0] dout;
  logic dout_valid, full, empty, buf_hw, buf_lw, overflow, underflow;
  logic [9:0] level;
  bit mq[$];
  logic [23:0] exp_q[$];
  logic m_hw, m_lw, m_ovf, m_unf, last_pa;
  int chk = 0, err = 0;

  width_conv_fifo dut (
    .clk143(clk143), .reset_n(reset_n), .we(we), .din(din), .pop_front(pop_front),
    .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid), .level(level), .full(full),
    .empty(empty), .buf_hw(buf_hw), .buf_lw(buf_lw), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk143 = ~clk143;

  task automatic do_reset();
    reset_n = 1'b0;
    we = 1'b0; din = '0; pop_front = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk143);
    #1 reset_n = 1'b1;
    mq.delete(); exp_q.delete();
    m_hw = 1'b0; m_lw = 1'b1; m_ovf = 1'b0; m_unf = 1'b0; last_pa = 1'b0;
  endtask

  task automatic step(input logic w, input logic [15:0] d, input logic p, input logic c);
    logic [23:0] word;
    int lv;
    bit wa, pa;
    we = w; din = d; pop_front = p; clr_err = c;
    lv = mq.size();
    wa = w && (512 - lv >= 16);
    pa = p && (lv >= 24);
    if (pa) begin
      for (int i = 0; i < 24; i++) word[i] = mq.pop_front();
      exp_q.push_back(word);
    end
    if (wa) for (int i = 0; i < 16; i++) mq.push_back(d[i]);
    m_ovf = (w && !wa) || (m_ovf && !c);
    m_unf = (p && !pa) || (m_unf && !c);
    lv = mq.size();
    if (lv > 384) m_hw = 1'b1; else if (lv <= 352) m_hw = 1'b0;
    if (lv < 128) m_lw = 1'b1; else if (lv >= 160) m_lw = 1'b0;
    last_pa = pa;
    @(posedge clk143); #1;
    we = 1'b0; pop_front = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk++;
    if ({level, empty, full, buf_lw, buf_hw, dout_valid, overflow, underflow} !== {10'd0, 7'b1010000})
      begin err++; $display("FAIL reset: level=%0d e/f/lw/hw/dv/ov/un=%b%b%b%b%b%b%b required level=0 1010000",
        level, empty, full, buf_lw, buf_hw, dout_valid, overflow, underflow); end
  endtask

  task automatic test_basic();
    logic [23:0] e;
    do_reset();
    step(1, 16'hBBAA, 0, 0); step(1, 16'hDDCC, 0, 0); step(1, 16'hFFEE, 0, 0);
    chk++; if (level !== 10'd48) begin err++; $display("FAIL basic_level48 got %0d want 48", level); end
    step(0, 0, 1, 0);
    e = exp_q.pop_front();
    chk++; if (dout_valid !== 1'b1 || dout !== 24'hCCBBAA || level !== 10'd24)
      begin err++; $display("FAIL basic_pop1 dv=%b dout=%h level=%0d want 1 ccbbaa 24 (model %h)", dout_valid, dout, level, e); end
    step(0, 0, 0, 0);
    chk++; if (dout_valid !== 1'b0) begin err++; $display("FAIL basic_dv_pulse got %b want 0", dout_valid); end
    step(0, 0, 1, 0);
    e = exp_q.pop_front();
    chk++; if (dout_valid !== 1'b1 || dout !== 24'hFFEEDD || level !== 10'd0)
      begin err++; $display("FAIL basic_pop2 dv=%b dout=%h level=%0d want 1 ffeedd 0 (model %h)", dout_valid, dout, level, e); end
  endtask

  task automatic test_underflow();
    logic [23:0] e, held;
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 16'(16'h1111 * (i + 1)), 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 0);
      e = exp_q.pop_front();
      chk++; if (dout !== e) begin err++; $display("FAIL uf_setup_dout got %h want %h", dout, e); end
    end
    held = e;
    step(0, 0, 1, 0);
    chk++; if (underflow !== 1'b1 || dout_valid !== 1'b0 || level !== 10'd16 || dout !== held)
      begin err++; $display("FAIL underflow uf=%b dv=%b level=%0d dout=%h want 1 0 16 %h", underflow, dout_valid, level, dout, held); end
    step(0, 0, 0, 1);
    chk++; if (underflow !== 1'b0) begin err++; $display("FAIL uf_clear got %b want 0", underflow); end
  endtask

  task automatic test_full_and_watermarks();
    logic [23:0] e;
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      step(1, 16'(i * 16'h0301 + 7), 0, 0);
      if (i == 24) begin chk++; if (buf_hw !== 1'b0 || level !== 10'd384) begin err++; $display("FAIL hw_at_384 hw=%b level=%0d want 0 384", buf_hw, level); end end
      if (i == 25) begin chk++; if (buf_hw !== 1'b1 || level !== 10'd400) begin err++; $display("FAIL hw_at_400 hw=%b level=%0d want 1 400", buf_hw, level); end end
    end
    chk++; if (level !== 10'd512 || full !== 1'b1 || overflow !== 1'b0)
      begin err++; $display("FAIL full512 level=%0d full=%b ov=%b want 512 1 0", level, full, overflow); end
    step(1, 16'hDEAD, 0, 0);
    chk++; if (overflow !== 1'b1 || level !== 10'd512) begin err++; $display("FAIL overflow ov=%b level=%0d want 1 512", overflow, level); end
    step(1, 16'hBEEF, 0, 1);
    chk++; if (overflow !== 1'b1) begin err++; $display("FAIL clr_vs_new_err ov=%b want 1", overflow); end
    step(0, 0, 0, 1);
    chk++; if (overflow !== 1'b0) begin err++; $display("FAIL ov_clear ov=%b want 0", overflow); end
    while (mq.size() >= 24) begin
      step(0, 0, 1, 0);
      e = exp_q.pop_front();
      chk++; if (dout !== e || dout_valid !== 1'b1) begin err++; $display("FAIL drain_dout got %h dv=%b want %h", dout, dout_valid, e); end
      chk++; if (buf_hw !== m_hw || buf_lw !== m_lw || buf_hw !== (level > 10'd352) || level !== 10'(mq.size()))
        begin err++; $display("FAIL drain_wm level=%0d hw=%b lw=%b want level %0d hw %b lw %b", level, buf_hw, buf_lw, mq.size(), m_hw, m_lw); end
    end
    while (mq.size() < 200) begin
      step(1, 16'h5A5A, 0, 0);
      chk++; if (buf_lw !== m_lw || buf_lw !== (level < 10'd160)) begin err++; $display("FAIL refill_lw level=%0d lw=%b want %b", level, buf_lw, m_lw); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] e;
    do_reset();
    step(1, 16'h0123, 0, 0); step(1, 16'h4567, 0, 0); step(1, 16'h89AB, 0, 0);
    step(0, 0, 1, 0);
    e = exp_q.pop_front();
    chk++; if (dout !== 24'h670123) begin err++; $display("FAIL b2b_first got %h want 670123", dout); end
    step(1, 16'hCDEF, 1, 0);
    e = exp_q.pop_front();
    chk++; if (level !== 10'd16 || dout !== 24'h89AB45 || dout_valid !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0)
      begin err++; $display("FAIL b2b_simul level=%0d dout=%h dv=%b ov=%b uf=%b want 16 89ab45 1 0 0 (model %h)", level, dout, dout_valid, overflow, underflow, e); end
  endtask

  task automatic test_stream();
    int npops = 0;
    logic [23:0] e;
    logic [6:0] exp_f;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c < 250) step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 1) == 1, 0);
      else step($urandom_range(0, 9) < 9, 16'($urandom), $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0);
      exp_f = {(512 - mq.size() < 16), (mq.size() < 24), m_hw, m_lw, m_ovf, m_unf, last_pa};
      chk++; if (level !== 10'(mq.size()) || {full, empty, buf_hw, buf_lw, overflow, underflow, dout_valid} !== exp_f)
        begin err++; $display("FAIL stream_state cyc %0d level=%0d flags=%b want %0d %b", c, level, {full, empty, buf_hw, buf_lw, overflow, underflow, dout_valid}, mq.size(), exp_f); end
      if (last_pa) begin
        npops++;
        e = exp_q.pop_front();
        chk++; if (dout !== e) begin err++; $display("FAIL stream_dout pop %0d got %h want %h", npops, dout, e); end
      end
    end
    chk++; if (npops < 22) begin err++; $display("FAIL stream_wrap pops=%0d want >=22", npops); end
  endtask

  task automatic test_mid_reset();
    logic [23:0] e;
    do_reset();
    step(1, 16'hAAAA, 0, 0); step(1, 16'hBBBB, 0, 0); step(1, 16'hCCCC, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk++; if (level !== 10'd0 || empty !== 1'b1 || buf_lw !== 1'b1)
      begin err++; $display("FAIL async_reset level=%0d empty=%b lw=%b want 0 1 1", level, empty, buf_lw); end
    do_reset();
    step(1, 16'h1357, 0, 0); step(1, 16'h9BDF, 0, 0); step(0, 0, 1, 0);
    e = exp_q.pop_front();
    chk++; if (dout !== 24'hDF1357 || dout_valid !== 1'b1 || level !== 10'd8)
      begin err++; $display("FAIL post_reset_pop dout=%h dv=%b level=%0d want df1357 1 8 (model %h)", dout, dout_valid, level, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_full_and_watermarks();
    test_back_to_back();
    test_stream();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
